// File: rtl/ahfp_pkg.sv
// ahfp_pkg: definitions shared by the ahfp floating-point blocks
// (ahfp_int_to_float today, ahfp_add_sub later).
// Contents: FSM state enum, default exponent bias, IEEE-754 single field
// widths, the +0 encoding, and the round-to-nearest-even increment decision.
package ahfp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } ahfp_state_e;

  localparam int          EXP_BIAS_DEF = 127;
  localparam int          EXP_W        = 8;
  localparam int          FRAC_W       = 23;
  localparam logic [31:0] FP_ZERO      = 32'h00000000;

  // Round up when above half an ulp, or exactly half an ulp with an odd lsb.
  function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/ahfp_int_to_float_if.sv
// ahfp_int_to_float_if: valid/ready bundle for the integer-to-float converter.
//   in_valid/in_ready/dataa    : integer operand handshake
//   out_valid/out_ready/result : IEEE-754 single result handshake
// The master modport is the side that supplies operands and takes results;
// the slave modport is the converter.
interface ahfp_int_to_float_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dataa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport master (output in_valid, output dataa, output out_ready,
                  input  in_ready, input  out_valid, input  result);
  modport slave  (input  in_valid, input  dataa, input  out_ready,
                  output in_ready, output out_valid, output result);
endinterface

// File: rtl/ahfp_rne_round.sv
// ahfp_rne_round: combinational rounding of a normalised fraction.
//   frac     : 23 fraction bits below the hidden one
//   guard    : first bit below the fraction lsb
//   sticky   : OR of all remaining lower bits
//   frac_rnd : rounded fraction
//   carry    : fraction wrapped from all ones to zero; the exponent must step
// Macro AHFP_I2F_TRUNC_EN selects round toward zero (no increment ever);
// otherwise round-to-nearest-even.
module ahfp_rne_round
  import ahfp_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac_rnd,
  output logic              carry
);

`ifdef AHFP_I2F_TRUNC_EN
  // Truncation: the fraction passes through untouched.
  always_comb begin
    frac_rnd = frac;
    carry    = 1'b0;
  end
`else
  logic inc_s;

  // Nearest-even increment; the carry-out flags the all-ones wrap.
  always_comb begin
    inc_s             = rne_inc(guard, sticky, frac[0]);
    {carry, frac_rnd} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc_s};
  end
`endif

endmodule

// File: rtl/ahfp_int_to_float.sv
// ahfp_int_to_float: sequential signed 32-bit integer to IEEE-754 single converter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ahfp_int_to_float_if slave (in_valid/in_ready/dataa,
//           out_valid/out_ready/result)
// Parameters: NORM_STEP (1 or 4) left-shift per NORM cycle; with 4 a 4-bit
// shift is used while the top nibble is zero. EXP_BIAS is the exponent bias.
// Macro AHFP_I2F_TRUNC_EN (in ahfp_rne_round) selects round toward zero.
// All handshake outputs are registered; in_ready is high only in IDLE.
module ahfp_int_to_float
  import ahfp_pkg::*;
#(
  parameter int NORM_STEP = 1,
  parameter int EXP_BIAS  = EXP_BIAS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ahfp_int_to_float_if.slave    bus
);

  // Exponent of a value whose leading one sits in bit 31.
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(EXP_BIAS + 31);

  ahfp_state_e       state_r, state_nx;
  logic [31:0]       mag_r, mag_nx;
  logic [EXP_W-1:0]  exp_r, exp_nx;
  logic              sign_r, sign_nx;
  logic [31:0]       result_r, result_nx;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [FRAC_W-1:0] frac_rnd_s;
  logic              carry_s;

  ahfp_rne_round u_round (
    .frac     (mag_r[30:8]),
    .guard    (mag_r[7]),
    .sticky   (|mag_r[6:0]),
    .frac_rnd (frac_rnd_s),
    .carry    (carry_s)
  );

  // Next-state and datapath update for the IDLE/NORM/ROUND/OUT sequence.
  always_comb begin
    state_nx  = state_r;
    mag_nx    = mag_r;
    exp_nx    = exp_r;
    sign_nx   = sign_r;
    result_nx = result_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          sign_nx = bus.dataa[31];
          // Two's-complement negate; -2^31 wraps to 32'h80000000 as wanted.
          mag_nx  = bus.dataa[31] ? (~bus.dataa + 32'd1) : bus.dataa;
          exp_nx  = EXP_INIT;
          if (bus.dataa == 32'd0) begin
            result_nx = FP_ZERO;
            state_nx  = ST_OUT;
          end else begin
            state_nx  = ST_NORM;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_NORM: begin
        if (mag_r[31]) begin
          state_nx = ST_ROUND;
        end else if ((NORM_STEP == 4) && (mag_r[31:28] == 4'h0)) begin
          mag_nx = {mag_r[27:0], 4'h0};
          exp_nx = exp_r - EXP_W'(4);
        end else begin
          mag_nx = {mag_r[30:0], 1'b0};
          exp_nx = exp_r - EXP_W'(1);
        end
      end
      ST_ROUND: begin
        // Exponent never exceeds 158 for nonzero input, so the carry cannot overflow it.
        result_nx = {sign_r, exp_r + {{(EXP_W-1){1'b0}}, carry_s}, frac_rnd_s};
        state_nx  = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_OUT;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mag_r       <= 32'd0;
      exp_r       <= {EXP_W{1'b0}};
      sign_r      <= 1'b0;
      result_r    <= FP_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      mag_r       <= mag_nx;
      exp_r       <= exp_nx;
      sign_r      <= sign_nx;
      result_r    <= result_nx;
      in_ready_r  <= (state_nx == ST_IDLE);
      out_valid_r <= (state_nx == ST_OUT);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;

endmodule

// File: tb/tb_ahfp_int_to_float.sv
// tb_ahfp_int_to_float: directed self-checking bench for ahfp_int_to_float.
// Two instances share clock and reset: u_dut (NORM_STEP=1) and u_dut4 (NORM_STEP=4).
// Expected results and latencies are hand-computed from the conversion rules.
module tb_ahfp_int_to_float;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nfail;

  ahfp_int_to_float_if m ();
  ahfp_int_to_float_if m4 ();

  ahfp_int_to_float #(.NORM_STEP(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(m));
  ahfp_int_to_float #(.NORM_STEP(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(m4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Convert one operand on u_dut from IDLE; checks result, latency and return to IDLE.
  task automatic run(input logic [31:0] a, input logic [31:0] expv, input int lat_exp,
                     input string tag);
    int lat;
    m.in_valid = 1'b1;
    m.dataa    = a;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    lat = 1;
    while (!m.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(m.result, expv, {tag, " result"});
    chk(32'(lat), 32'(lat_exp), {tag, " latency"});
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.out_ready = 1'b0;
    chk({30'd0, m.out_valid, m.in_ready}, 32'd1, {tag, " idle after handshake"});
  endtask

  initial begin
    logic [31:0] held;
    int          lat4;
    int          seen;
    nvec  = 0;
    nfail = 0;
    m.in_valid   = 1'b0;  m.dataa  = 32'd0; m.out_ready  = 1'b0;
    m4.in_valid  = 1'b0;  m4.dataa = 32'd0; m4.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({30'd0, m.out_valid, m.in_ready}, 32'd1, "reset handshake");
    chk(m.result, 32'h00000000, "reset result");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(32'h00000001, 32'h3F800000, 34, "one");
    run(32'h00000003, 32'h40400000, 33, "three");
    run(32'hFFFFFFFE, 32'hC0000000, 33, "minus_two");
    run(32'h00000000, 32'h00000000, 1,  "zero");
    run(32'h01000001, 32'h4B800000, 10, "tie_even_kept");
    run(32'h01000003, 32'h4B800002, 10, "tie_round_up");
`ifdef AHFP_I2F_TRUNC_EN
    run(32'h7FFFFFFF, 32'h4EFFFFFF, 4,  "max_pos_trunc");
`else
    run(32'h7FFFFFFF, 32'h4F000000, 4,  "max_pos_carry");
`endif
    run(32'h80000000, 32'hCF000000, 3,  "min_neg");
    run(32'hFFFFFFFF, 32'hBF800000, 34, "minus_one");

    // Backpressure: result held in OUT, new operand refused while busy.
    m.in_valid = 1'b1;
    m.dataa    = 32'h00000003;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    seen = 0;
    while (!m.out_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    held = 32'h40400000;
    m.in_valid = 1'b1;
    m.dataa    = 32'h00000005;
    for (int i = 0; i < 5; i++) begin
      chk({31'd0, m.out_valid}, 32'd1, "bp out_valid held");
      chk(m.result, held, "bp result stable");
      chk({31'd0, m.in_ready}, 32'd0, "bp in_ready low");
      @(posedge clk); #1;
    end
    m.in_valid  = 1'b0;
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.out_ready = 1'b0;
    chk({30'd0, m.out_valid, m.in_ready}, 32'd1, "bp release to idle");
    chk(m.result, held, "bp result kept after handshake");
    run(32'hFFFFFFFE, 32'hC0000000, 33, "after_bp");

    // NORM_STEP=4 instance: same result, fewer cycles.
    m4.in_valid = 1'b1;
    m4.dataa    = 32'h00000001;
    @(posedge clk); #1;
    m4.in_valid = 1'b0;
    lat4 = 1;
    while (!m4.out_valid && lat4 < 100) begin
      @(posedge clk); #1;
      lat4++;
    end
    chk(m4.result, 32'h3F800000, "step4 one result");
    chk({31'd0, (lat4 < 34)}, 32'd1, "step4 faster than step1");
    m4.out_ready = 1'b1;
    @(posedge clk); #1;
    m4.out_ready = 1'b0;
    chk({30'd0, m4.out_valid, m4.in_ready}, 32'd1, "step4 idle after handshake");

    // Reset in the middle of NORM abandons the conversion.
    m.in_valid = 1'b1;
    m.dataa    = 32'h00000001;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk({30'd0, m.out_valid, m.in_ready}, 32'd1, "midnorm reset handshake");
    chk(m.result, 32'h00000000, "midnorm reset result");
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m.out_valid) seen++;
    end
    chk(32'(seen), 32'd0, "no output after reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
